// File: rtl/bus_xfer_pkg.sv
// Shared types and constants for the bus transfer controller.
package bus_xfer_pkg;

  localparam int unsigned BUS_W    = 8;
  localparam int unsigned MAX_REGS = 16;

  localparam logic [MAX_REGS-1:0] STROBE_IDLE = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WRITE = 2'd2,
    TURN  = 2'd3
  } xfer_state_t;

endpackage

// File: rtl/bus_xfer_ctrl_sel_decode.sv
// Register select decoder: index + enable to active-low one-hot strobes, with range flag.
module bus_sel_decode
  import bus_xfer_pkg::*;
#(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned SEL_W    = $clog2(NUM_REGS)
) (
  input  logic [SEL_W-1:0]    sel,
  input  logic                en,
  output logic [NUM_REGS-1:0] strb_n,
  output logic                oor
);

  always_comb begin
    strb_n = STROBE_IDLE[NUM_REGS-1:0];
    oor    = (32'(sel) >= NUM_REGS);
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (en && !oor && (32'(sel) == i)) begin
        strb_n[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Bus initiator sequencing one reg->reg or imm->reg transfer per request.
// Optional snoop register enabled by defining BUS_XFER_SNOOP_EN.
module bus_xfer_ctrl
  import bus_xfer_pkg::*;
#(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned SEL_W    = $clog2(NUM_REGS)
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_src_imm,
  input  logic [SEL_W-1:0]    i_src_sel,
  input  logic [SEL_W-1:0]    i_dst_sel,
  input  logic [BUS_W-1:0]    i_imm_data,
  inout  wire  [BUS_W-1:0]    io_bus_data,
  output logic [NUM_REGS-1:0] o_rdn,
  output logic [NUM_REGS-1:0] o_wrtn,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
  output logic [BUS_W-1:0]    o_snoop_data
);

  xfer_state_t      state;
  logic             src_imm_q;
  logic [SEL_W-1:0] src_q;
  logic [SEL_W-1:0] dst_q;
  logic [BUS_W-1:0] imm_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic             idle;
  logic             xfer_active;
  logic [SEL_W-1:0] rd_sel;
  logic [SEL_W-1:0] wr_sel;
  logic             src_oor;
  logic             dst_oor;
  logic             req_bad;

  assign idle        = (state == IDLE);
  assign xfer_active = (state == SETUP) || (state == WRITE);

  // In IDLE the decoders range-check the incoming request (strobes disabled);
  // otherwise they decode the captured selects.
  assign rd_sel = idle ? i_src_sel : src_q;
  assign wr_sel = idle ? i_dst_sel : dst_q;

  bus_sel_decode #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_rd_decode (
    .sel    (rd_sel),
    .en     (xfer_active && !src_imm_q),
    .strb_n (o_rdn),
    .oor    (src_oor)
  );

  bus_sel_decode #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_wr_decode (
    .sel    (wr_sel),
    .en     (state == WRITE),
    .strb_n (o_wrtn),
    .oor    (dst_oor)
  );

  assign req_bad = (!i_src_imm && src_oor) || dst_oor;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= IDLE;
      src_imm_q <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      imm_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            if (req_bad) begin
              err_q <= 1'b1;
            end else begin
              src_imm_q <= i_src_imm;
              src_q     <= i_src_sel;
              dst_q     <= i_dst_sel;
              imm_q     <= i_imm_data;
              busy_q    <= 1'b1;
              state     <= SETUP;
            end
          end
        end
        SETUP: state <= WRITE;
        WRITE: begin
          done_q <= 1'b1;
          state  <= TURN;
        end
        TURN: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io_bus_data = (xfer_active && src_imm_q) ? imm_q : 'z;

  assign o_req_ready = idle;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

`ifdef BUS_XFER_SNOOP_EN
  logic [BUS_W-1:0] snoop_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      snoop_q <= '0;
    end else if (state == WRITE) begin
      snoop_q <= io_bus_data;
    end
  end

  assign o_snoop_data = snoop_q;
`else
  assign o_snoop_data = '0;
`endif

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Scoreboard bench for bus_xfer_ctrl with a behavioural register bank on the bus.
module tb_bus_xfer_ctrl;
  import bus_xfer_pkg::*;

  localparam int unsigned NUM = 4;
  localparam int unsigned SW  = 3;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic           src_imm = 1'b0;
  logic [SW-1:0]  src_sel = '0;
  logic [SW-1:0]  dst_sel = '0;
  logic [7:0]     imm_data = '0;
  wire  [7:0]     bus_data;
  logic [NUM-1:0] rdn;
  logic [NUM-1:0] wrtn;
  logic           busy;
  logic           done;
  logic           err;
  logic [7:0]     snoop;

  always #5 clk = ~clk;

  bus_xfer_ctrl #(.NUM_REGS(NUM), .SEL_W(SW)) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_src_imm    (src_imm),
    .i_src_sel    (src_sel),
    .i_dst_sel    (dst_sel),
    .i_imm_data   (imm_data),
    .io_bus_data  (bus_data),
    .o_rdn        (rdn),
    .o_wrtn       (wrtn),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err),
    .o_snoop_data (snoop)
  );

  logic [7:0]    regs [NUM];
  logic          pl_en = 1'b0;
  int unsigned   pl_idx = 0;
  logic [7:0]    pl_val = '0;
  logic          drv_en;
  logic [7:0]    drv_val;

  always_comb begin
    drv_en  = 1'b0;
    drv_val = '0;
    for (int i = 0; i < NUM; i++) begin
      if (!rdn[i]) begin
        drv_en  = 1'b1;
        drv_val = regs[i];
      end
    end
  end

  assign bus_data = drv_en ? drv_val : 'z;

  always @(posedge clk) begin
    if (pl_en) regs[pl_idx] <= pl_val;
    for (int i = 0; i < NUM; i++) begin
      if (!wrtn[i]) regs[i] <= bus_data;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    bit         imm;
    int         src;
    int         dst;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  int         wr_cnt = 0;
  int         rd_cnt = 0;
  logic [NUM-1:0] wr_seen = '0;
  logic [NUM-1:0] rd_seen = '0;
  logic [7:0] snoop_exp = '0;
  exp_t       e;

  // Monitor: per-cycle bus invariants, and pops the scoreboard on done/err.
  always @(negedge clk) begin
    if (!rstn) begin
      wr_cnt    = 0;
      rd_cnt    = 0;
      snoop_exp = '0;
    end else begin
      if (rdn != '1) begin
        rd_cnt++;
        rd_seen = ~rdn;
        chk("rdn_one_hot", $countones(~rdn), 1);
        if (q.size() > 0 && q[0].imm) chk("rdn_during_imm", int'(~rdn), 0);
      end
      if (wrtn != '1) begin
        wr_cnt++;
        wr_seen = ~wrtn;
        if (q.size() == 0) begin
          chk("wrtn_without_xfer", int'(~wrtn), 0);
        end else begin
          chk("single_driver",
              int'(q[0].imm ? (rdn == '1) : ($countones(~rdn) == 1)), 1);
          chk("bus_value", int'(bus_data), int'(q[0].data));
        end
      end
      if (done || err) begin
        if (q.size() == 0) begin
          chk("unexpected_event", int'({done, err}), 0);
        end else begin
          e = q.pop_front();
          chk("event_kind", int'(err), int'(e.is_err));
          chk("event_cycle", cyc, e.due);
          if (e.is_err) begin
            chk("err_no_wrtn", wr_cnt, 0);
            chk("err_no_rdn", rd_cnt, 0);
            chk("err_busy", int'(busy), 0);
          end else begin
            chk("wrtn_cycles", wr_cnt, 1);
            chk("wrtn_bit", int'(wr_seen), 1 << e.dst);
            chk("rdn_cycles", rd_cnt, e.imm ? 0 : 2);
            if (!e.imm) chk("rdn_bit", int'(rd_seen), 1 << e.src);
            chk("dst_value", int'(regs[e.dst]), int'(e.data));
`ifdef BUS_XFER_SNOOP_EN
            snoop_exp = e.data;
`endif
            chk("snoop_at_done", int'(snoop), int'(snoop_exp));
          end
        end
        wr_cnt = 0;
        rd_cnt = 0;
      end
    end
  end

  task automatic preload(input int unsigned idx, input logic [7:0] val);
    @(negedge clk);
    pl_idx = idx;
    pl_val = val;
    pl_en  = 1'b1;
    @(negedge clk);
    pl_en  = 1'b0;
  endtask

  // Leaves req_valid high on return; inputs are scrambled after acceptance.
  task automatic issue(input bit imm, input int src, input int dst, input logic [7:0] data,
                       input bit exp_err, input bit push, output int acc);
    exp_t x;
    src_imm   = imm;
    src_sel   = SW'(src);
    dst_sel   = SW'(dst);
    imm_data  = imm ? data : ~data;
    req_valid = 1'b1;
    acc = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      chk("accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    if (push) begin
      x.is_err = exp_err;
      x.imm    = imm;
      x.src    = src;
      x.dst    = dst;
      x.data   = data;
      x.due    = acc + (exp_err ? 1 : 3);
      q.push_back(x);
    end
    @(posedge clk);
    #1;
    src_imm  = ~src_imm;
    src_sel  = ~src_sel;
    dst_sel  = ~dst_sel;
    imm_data = ~imm_data;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || q.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("idle_timeout", n, 0);
    @(posedge clk);
    #1;
  endtask

  int a1, a2;

  initial begin
    #12;
    chk("rst_rdn", int'(rdn), 4'hF);
    chk("rst_wrtn", int'(wrtn), 4'hF);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_snoop", int'(snoop), 0);
    preload(0, 8'h3C);
    preload(1, 8'h77);
    preload(2, 8'h00);
    preload(3, 8'h00);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    issue(1'b1, 0, 2, 8'hA5, 1'b0, 1'b1, a1);
    req_valid = 1'b0;
    wait_idle();

    issue(1'b0, 0, 3, 8'h3C, 1'b0, 1'b1, a1);
    req_valid = 1'b0;
    wait_idle();
    chk("src_unchanged", int'(regs[0]), 8'h3C);

    issue(1'b1, 0, 0, 8'h11, 1'b0, 1'b1, a1);
    issue(1'b0, 2, 1, 8'hA5, 1'b0, 1'b1, a2);
    req_valid = 1'b0;
    chk("b2b_spacing", a2 - a1, 4);
    wait_idle();

    issue(1'b1, 0, 5, 8'h99, 1'b1, 1'b1, a1);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("bad_dst_busy", int'(busy), 0);
    chk("bad_dst_ready", int'(req_ready), 1);
    @(posedge clk);
    #1;

    issue(1'b0, 6, 0, 8'h00, 1'b1, 1'b1, a1);
    req_valid = 1'b0;
    wait_idle();

    issue(1'b1, 7, 0, 8'h42, 1'b0, 1'b1, a1);
    req_valid = 1'b0;
    wait_idle();

    issue(1'b0, 1, 1, 8'hA5, 1'b0, 1'b1, a1);
    req_valid = 1'b0;
    wait_idle();

    issue(1'b1, 0, 1, 8'h5A, 1'b0, 1'b1, a1);
    req_valid = 1'b0;
    wait_idle();
`ifdef BUS_XFER_SNOOP_EN
    chk("snoop_hold", int'(snoop), 8'h5A);
`else
    chk("snoop_hold", int'(snoop), 8'h00);
`endif

    issue(1'b0, 0, 2, 8'h42, 1'b0, 1'b0, a1);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("write_wrtn", int'(wrtn), 4'b1011);
    chk("write_rdn", int'(rdn), 4'b1110);
    rstn = 1'b0;
    #1;
    chk("rst_mid_rdn", int'(rdn), 4'hF);
    chk("rst_mid_wrtn", int'(wrtn), 4'hF);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_done", int'(done), 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_ready", int'(req_ready), 1);
    chk("post_rst_snoop", int'(snoop), 0);
    chk("post_rst_busy", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_xfer_ctrl.md
Name: bus_xfer_ctrl

Overview:
Bus initiator for the shared 8-bit tri-state data bus. It sequences one transfer per request: register-to-register, or immediate-to-register.
- Drives the active-low read strobe (rdn) of the source register and the active-low write strobe (wrtn) of the destination register.
- Drives immediate data onto the bus itself.
- Sits between the control sequencer and the bank of 8-bit bus registers.

Parameters:
- NUM_REGS, 4, number of bus registers controlled; valid range 2..16.
- SEL_W, $clog2(NUM_REGS), width of the source/destination select fields.

Ports:
- i_clk  input  1  clock.
- i_rstn  input  1  reset; asynchronous, active-low.
- i_req_valid  input  1  transfer request.
- o_req_ready  output  1  high only in IDLE; a transfer is accepted when i_req_valid and o_req_ready are both high at a rising edge.
- i_src_imm  input  1  1 = source is i_imm_data; 0 = source is register i_src_sel.
- i_src_sel  input  SEL_W  source register index.
- i_dst_sel  input  SEL_W  destination register index.
- i_imm_data  input  8  immediate value.
- io_bus_data  inout  8  shared data bus; driven only for immediate transfers, otherwise Z.
- o_rdn  output  NUM_REGS  per-register read strobes, active-low.
- o_wrtn  output  NUM_REGS  per-register write strobes, active-low.
- o_busy  output  1  high in any state other than IDLE.
- o_done  output  1  one-cycle pulse when a transfer completes.
- o_err  output  1  one-cycle pulse when a request is rejected.
- o_snoop_data  output  8  last value transferred (optional feature only).

Behaviour:
Reset (async, takes effect immediately):
- o_rdn and o_wrtn all 1s.
- Bus released (Z).
- o_busy=0, o_done=0, o_err=0, o_snoop_data=0, o_req_ready=1.
- State returns to IDLE.

Request capture:
- On acceptance, i_src_imm, i_src_sel, i_dst_sel and i_imm_data are registered.
- Later input changes have no effect on the transfer in flight.

State machine; all strobes and the bus enable are decoded from registered state (glitch-free):
- IDLE: all strobes high, bus Z.
  - Accept with any select >= NUM_REGS: o_err pulses next cycle, state stays IDLE, no strobe asserted.
  - Accept with valid selects: go to SETUP.
- SETUP (1 cycle): source rdn low (register source) or controller drives imm (immediate source); all wrtn high; bus settles. Go to WRITE.
- WRITE (1 cycle): source drive is held; destination wrtn low. The destination latches the bus on the rising edge that ends WRITE. Go to TURN.
- TURN (1 cycle): all strobes high, bus Z; o_done high during this cycle. Go to IDLE.

Latency and strobe rules:
- Acceptance edge to o_done is 3 cycles.
- Next acceptance is possible at the edge ending TURN, plus one cycle (IDLE), so throughput is 4 cycles per transfer.
- Invariants:
  - At most one bus driver: never more than one o_rdn bit low, and never rdn low while the controller drives the bus.
  - Exactly one wrtn bit low, for exactly one cycle, per transfer.
  - wrtn is never low without a valid driver on the bus.

Boundary conditions:
- src_sel == dst_sel with a register source: legal; the register rewrites its own value.
- i_src_sel is ignored when i_src_imm=1; only i_dst_sel is range-checked.
- i_req_valid while busy: not accepted; the requester must hold it.
- Reset mid-transfer (SETUP or WRITE): strobes deassert asynchronously. No o_done is produced. The destination may or may not have latched; that is reported as undefined.

Optional Feature:
- Macro: BUS_XFER_SNOOP_EN.
- Defined: o_snoop_data registers io_bus_data at the edge ending WRITE, holds it until the next completed transfer, and resets to 0.
- Undefined: o_snoop_data is tied to 8'h00 and no snoop flops exist.

Decomposition:
- Package bus_xfer_pkg:
  - BUS_W=8.
  - typedef enum xfer_state_t {IDLE, SETUP, WRITE, TURN}.
  - STROBE_IDLE constant (all-ones helper).
- Sub-module bus_sel_decode: index plus enable in, active-low one-hot strobe vector out, out-of-range flag out. It is instantiated twice, once for rdn and once for wrtn.

Test Plan:
1. Immediate write: reset, req imm=1, dst=2, data=8'hA5 -> o_wrtn[2] low exactly 1 cycle; reg2 reads 8'hA5; o_done 3 cycles after acceptance; bus Z in IDLE.
2. Reg-to-reg: preload reg0=8'h3C, req src=0, dst=3 -> o_rdn[0] low for SETUP+WRITE, o_wrtn[3] low in WRITE only; reg3=8'h3C; reg0 unchanged.
3. Back-to-back: valid held high with two requests -> second accepted 4 cycles after first; both o_done pulses seen; no cycle with two drivers (checked by assertion).
4. Bad select: NUM_REGS=4, dst=5 -> o_err pulse, no strobe low, o_busy stays 0.
5. Reset in WRITE: assert i_rstn low mid-WRITE -> all strobes high in the same cycle, no o_done, o_req_ready=1 after release.
6. BUS_XFER_SNOOP_EN: imm 8'h5A to dst=1 -> o_snoop_data=8'h5A after WRITE. Without the macro -> stays 8'h00.
